// File: rtl/soc_led_seq_pkg.sv
// soc_led_seq_pkg: shared register map, CTRL bit positions and master FSM states
// for the LED sequencer.
package soc_led_seq_pkg;

  localparam logic [1:0] CTRL_A    = 2'd0;
  localparam logic [1:0] PERIOD_A  = 2'd1;
  localparam logic [1:0] PATTERN_A = 2'd2;
  localparam logic [1:0] STATUS_A  = 2'd3;

  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_MODE_BIT = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } mst_state_t;

endpackage

// File: rtl/soc_led_seq_tick.sv
// soc_led_seq_tick: programmable divider. Counts 0..max(period,1)-1 while enabled,
// then emits a registered one-cycle tick and wraps. clr restarts the count.
module soc_led_seq_tick (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] period,
  output logic        tick
);

  logic [31:0] cnt_q;
  logic [31:0] last_cnt;

  // Terminal count; a period of 0 behaves like 1
  always_comb begin
    last_cnt = '0;
    if (period != '0) begin
      last_cnt = period - 32'd1;
    end
  end

  // Divider counter and tick pulse; counter freezes while disabled
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (en) begin
      if (cnt_q >= last_cnt) begin
        cnt_q <= '0;
        tick  <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 32'd1;
        tick  <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/soc_led_sequencer.sv
// soc_led_sequencer: autonomous LED blink/pattern sequencer that writes the LED PIO
// through an Avalon-MM master whenever the generated level changes.
// Optional feature macro: SOC_LED_SEQ_PATTERN_EN (pattern mode, PATTERN register,
// STATUS index field). Without it MODE, PATTERN and the index read 0.
module soc_led_sequencer #(
  parameter logic [31:0] PERIOD_RST  = 32'd50_000_000,
  parameter logic [7:0]  PATTERN_RST = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest,
  output logic        led_level
);
  import soc_led_seq_pkg::*;

  logic        cfg_wr, wr_ctrl, wr_period, wr_pattern;
  logic        ctrl_en_q;
  logic [31:0] period_q;
  logic        ctrl_mode;
  logic [7:0]  pattern;
  logic [2:0]  idx, idx_d;
  logic        mode_chg;
  logic        tick;
  logic        level_q, level_d, level_upd;

  mst_state_t  state_q, state_d;
  logic        cs_q, cs_d, wn_q, wn_d, wd_q, wd_d;
  logic        last_q, last_d, pend_q, pend_d;

  assign cfg_wr     = s_chipselect && !s_write_n;
  assign wr_ctrl    = cfg_wr && (s_address == CTRL_A);
  assign wr_period  = cfg_wr && (s_address == PERIOD_A);
  assign wr_pattern = cfg_wr && (s_address == PATTERN_A);

  // EN and PERIOD configuration registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_en_q <= 1'b0;
      period_q  <= PERIOD_RST;
    end else begin
      if (wr_ctrl)   ctrl_en_q <= s_writedata[CTRL_EN_BIT];
      if (wr_period) period_q  <= s_writedata;
    end
  end

`ifdef SOC_LED_SEQ_PATTERN_EN
  // MODE, PATTERN and pattern index registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_mode <= 1'b0;
      pattern   <= PATTERN_RST;
      idx       <= '0;
    end else begin
      if (wr_ctrl)    ctrl_mode <= s_writedata[CTRL_MODE_BIT];
      if (wr_pattern) pattern   <= s_writedata[7:0];
      idx <= idx_d;
    end
  end

  assign mode_chg = wr_ctrl && ctrl_en_q && (s_writedata[CTRL_MODE_BIT] != ctrl_mode);
`else
  assign ctrl_mode = 1'b0;
  assign pattern   = '0;
  assign idx       = '0;
  assign mode_chg  = 1'b0;

  logic unused_pattern;
  assign unused_pattern = ^{idx_d, wr_pattern, PATTERN_RST};
`endif

  soc_led_seq_tick u_tick (
    .clk    (clk),
    .reset  (reset),
    .en     (ctrl_en_q),
    .clr    (wr_ctrl || wr_period),
    .period (period_q),
    .tick   (tick)
  );

  // Next level/index: forced low while disabled, advanced on each tick
  always_comb begin
    level_d = level_q;
    idx_d   = idx;
    if (!ctrl_en_q) begin
      level_d = 1'b0;
    end else if (mode_chg) begin
      idx_d = '0;
    end else if (tick) begin
      if (ctrl_mode) begin
        idx_d   = idx + 3'd1;
        level_d = pattern[idx_d];
      end else begin
        level_d = ~level_q;
      end
    end
  end

  assign level_upd = (level_d != level_q);

  // Generated level register
  always_ff @(posedge clk) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= level_d;
  end

  // Master state and registered bus outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cs_q    <= 1'b0;
      wn_q    <= 1'b1;
      wd_q    <= 1'b0;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      wn_q    <= wn_d;
      wd_q    <= wd_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
    end
  end

  // Master next state: a level change after issue marks the next transfer as owed
  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    wn_d    = wn_q;
    wd_d    = wd_q;
    last_d  = last_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: begin
        if (pend_q || (level_q != last_q)) begin
          state_d = WRITE;
          cs_d    = 1'b1;
          wn_d    = 1'b0;
          wd_d    = level_q;
          pend_d  = level_upd;
        end
      end
      WRITE: begin
        pend_d = pend_q || level_upd;
        if (!m_waitrequest) begin
          state_d = IDLE;
          cs_d    = 1'b0;
          wn_d    = 1'b1;
          last_d  = wd_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_address    = '0;
  assign m_chipselect = cs_q;
  assign m_write_n    = wn_q;
  assign m_writedata  = {31'b0, wd_q};
  assign led_level    = level_q;

  // Combinational config readback
  always_comb begin
    s_readdata = '0;
    case (s_address)
      CTRL_A: begin
        s_readdata[CTRL_EN_BIT]   = ctrl_en_q;
        s_readdata[CTRL_MODE_BIT] = ctrl_mode;
      end
      PERIOD_A:  s_readdata      = period_q;
      PATTERN_A: s_readdata[7:0] = pattern;
      STATUS_A:  s_readdata[4:0] = {idx, (state_q == WRITE), level_q};
      default:   s_readdata      = '0;
    endcase
  end

endmodule

// File: tb/tb_soc_led_sequencer.sv
// tb_soc_led_sequencer: directed and randomized stimulus against a cycle-level
// behavioural model of the LED sequencer and its PIO writes.
module tb_soc_led_sequencer;

`ifdef SOC_LED_SEQ_PATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif
  localparam logic [31:0] P_RST = 32'd7;
  localparam logic [7:0]  PAT_RST = 8'h3C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  s_address = '0;
  logic        s_chipselect = 1'b0;
  logic        s_write_n = 1'b1;
  logic [31:0] s_writedata = '0;
  logic [31:0] s_readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        m_waitrequest = 1'b0;
  logic        led_level;

  soc_led_sequencer #(
    .PERIOD_RST  (P_RST),
    .PATTERN_RST (PAT_RST)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .s_address     (s_address),
    .s_chipselect  (s_chipselect),
    .s_write_n     (s_write_n),
    .s_writedata   (s_writedata),
    .s_readdata    (s_readdata),
    .m_address     (m_address),
    .m_chipselect  (m_chipselect),
    .m_write_n     (m_write_n),
    .m_writedata   (m_writedata),
    .m_waitrequest (m_waitrequest),
    .led_level     (led_level)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  bit          mon_on  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        md_en = 0, md_mode = 0;
  logic [31:0] md_period = P_RST;
  logic [7:0]  md_pat = PAT ? PAT_RST : 8'h00;
  int unsigned since = 0;      // enabled edges since the last counter clear
  bit          tick_vis = 0;   // a tick is visible during the current cycle
  logic [2:0]  md_idx = '0;
  logic        lvl = 0;
  logic        mb_busy = 0, mb_data = 0, mb_last = 0, mb_pend = 0;

  always @(posedge clk) begin
    bit wr, old_lvl, old_tick, old_en, mode_chg;
    int unsigned p;
    cyc++;
    if (reset) begin
      md_en = 0; md_mode = 0; md_period = P_RST; md_pat = PAT ? PAT_RST : 8'h00;
      since = 0; tick_vis = 0; md_idx = '0; lvl = 0;
      mb_busy = 0; mb_data = 0; mb_last = 0; mb_pend = 0;
    end else begin
      wr       = s_chipselect && !s_write_n;
      old_lvl  = lvl;
      old_tick = tick_vis;
      old_en   = md_en;
      mode_chg = wr && (s_address == 2'd0) && old_en && PAT && (s_writedata[1] != md_mode);
      if (!old_en) lvl = 0;
      else if (mode_chg) md_idx = '0;
      else if (old_tick) begin
        if (md_mode) begin
          md_idx = md_idx + 3'd1;
          lvl = md_pat[md_idx];
        end else begin
          lvl = !lvl;
        end
      end
      p = (md_period == 0) ? 1 : md_period;
      if (wr && (s_address == 2'd0 || s_address == 2'd1)) begin
        since = 0; tick_vis = 0;
      end else if (old_en) begin
        since++;
        tick_vis = ((since % p) == 0);
      end else begin
        tick_vis = 0;
      end
      if (mb_busy) begin
        mb_pend = mb_pend || (lvl != old_lvl);
        if (!m_waitrequest) begin
          mb_busy = 0;
          mb_last = mb_data;
        end
      end else if (mb_pend || (old_lvl != mb_last)) begin
        mb_busy = 1;
        mb_data = old_lvl;
        mb_pend = (lvl != old_lvl);
      end
      if (wr) begin
        case (s_address)
          2'd0: begin md_en = s_writedata[0]; md_mode = PAT ? s_writedata[1] : 1'b0; end
          2'd1: md_period = s_writedata;
          2'd2: if (PAT) md_pat = s_writedata[7:0];
          default: ;
        endcase
      end
    end
  end

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {30'b0, md_mode, md_en};
      2'd1:    return md_period;
      2'd2:    return {24'b0, md_pat};
      default: return {27'b0, (PAT ? md_idx : 3'b000), mb_busy, lvl};
    endcase
  endfunction

  // ---------------- monitor ----------------
  int unsigned iss_cyc[$];
  logic        iss_dat[$];
  logic        prev_cs = 0, prev_wd = 0;
  logic        pio_val = 0;

  always @(negedge clk) begin
    if (mon_on) begin
      check("led_level", {31'b0, led_level}, {31'b0, lvl});
      check("m_chipselect", {31'b0, m_chipselect}, {31'b0, mb_busy});
      check("m_write_n", {31'b0, m_write_n}, {31'b0, !mb_busy});
      check("m_writedata", m_writedata, {31'b0, mb_data});
      check("m_address", {30'b0, m_address}, 32'd0);
      if (m_chipselect && !prev_cs) begin
        iss_cyc.push_back(cyc);
        iss_dat.push_back(m_writedata[0]);
      end
      if (reset) pio_val = 0;
      else if (prev_cs && !m_chipselect) pio_val = prev_wd;
      prev_cs = m_chipselect;
      prev_wd = m_writedata[0];
    end
  end

  // ---------------- stimulus helpers ----------------
  int unsigned wr_cyc;

  task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    s_address = a; s_chipselect = 1; s_write_n = 0; s_writedata = d;
    @(posedge clk);
    #1;
    wr_cyc = cyc;
    s_chipselect = 0; s_write_n = 1;
  endtask

  task automatic cfg_rd(input logic [1:0] a, output logic [31:0] v);
    @(negedge clk);
    s_address = a; s_chipselect = 1; s_write_n = 1;
    #1;
    v = s_readdata;
    s_chipselect = 0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a);
    logic [31:0] v;
    cfg_rd(a, v);
    check(tag, v, model_rd(a));
  endtask

  task automatic run(input int unsigned n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clr_log();
    iss_cyc.delete();
    iss_dat.delete();
  endtask

  task automatic wait_cs(input string tag, input int unsigned max);
    bit seen;
    seen = 0;
    for (int unsigned i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      #1;
      if (m_chipselect) seen = 1;
    end
    check(tag, {31'b0, seen}, 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] v;
    repeat (3) @(negedge clk);
    reset = 0;
    mon_on = 1;

    // reset state
    cfg_rd(2'd0, v); check("rst_ctrl", v, 32'd0);
    cfg_rd(2'd1, v); check("rst_period", v, P_RST);
    cfg_rd(2'd2, v); check("rst_pattern", v, PAT ? {24'b0, PAT_RST} : 32'd0);
    cfg_rd(2'd3, v); check("rst_status", v, 32'd0);

    // blink, PERIOD=4: writes 1,0,1,0 every 4 cycles, first 6 cycles after enable
    cfg_wr(2'd1, 32'd4);
    cfg_wr(2'd0, 32'd1);
    clr_log();
    run(20);
    check("blink_cnt", iss_cyc.size(), 32'd4);
    if (iss_cyc.size() >= 4) begin
      check("blink_first", iss_cyc[0] - wr_cyc, 32'd6);
      for (int i = 0; i < 4; i++) begin
        check("blink_data", {31'b0, iss_dat[i]}, (i % 2 == 0) ? 32'd1 : 32'd0);
        if (i > 0) check("blink_gap", iss_cyc[i] - iss_cyc[i-1], 32'd4);
      end
    end
    rd_chk("blink_status", 2'd3);

    // PERIOD=0: tick every cycle, transfers back to back every 2 cycles
    cfg_wr(2'd1, 32'd0);
    clr_log();
    run(14);
    check("fast_cnt_ge4", {31'b0, iss_cyc.size() >= 4}, 32'd1);
    if (iss_cyc.size() >= 4) begin
      check("fast_gap1", iss_cyc[2] - iss_cyc[1], 32'd2);
      check("fast_gap2", iss_cyc[3] - iss_cyc[2], 32'd2);
    end
    cfg_wr(2'd0, 32'd0);
    run(8);
    check("fast_final_pio", {31'b0, pio_val}, 32'd0);
    rd_chk("fast_status", 2'd3);

    // stall with PERIOD=2: data/address stable for 10 cycles, then reissue
    m_waitrequest = 1;
    cfg_wr(2'd1, 32'd2);
    cfg_wr(2'd0, 32'd1);
    clr_log();
    wait_cs("stall_wait", 20);
    for (int i = 0; i < 10; i++) begin
      check("stall_cs", {31'b0, m_chipselect}, 32'd1);
      check("stall_wd", m_writedata, 32'd1);
      check("stall_addr", {30'b0, m_address}, 32'd0);
      @(negedge clk);
      #1;
    end
    m_waitrequest = 0;
    run(8);
    check("stall_reissue", {31'b0, iss_cyc.size() >= 2}, 32'd1);
    cfg_wr(2'd0, 32'd0);
    run(10);

`ifdef SOC_LED_SEQ_PATTERN_EN
    // pattern 1000_0001, PERIOD=3: one write of 1 at index 7, one of 0 at index 1
    cfg_wr(2'd2, 32'h81);
    cfg_wr(2'd1, 32'd3);
    cfg_wr(2'd0, 32'd3);
    clr_log();
    run(36);
    check("pat_cnt", iss_cyc.size(), 32'd2);
    if (iss_cyc.size() >= 2) begin
      check("pat_d0", {31'b0, iss_dat[0]}, 32'd1);
      check("pat_d1", {31'b0, iss_dat[1]}, 32'd0);
      check("pat_gap", iss_cyc[1] - iss_cyc[0], 32'd6);
    end
    rd_chk("pat_status", 2'd3);
    rd_chk("pat_ctrl", 2'd0);
`else
    // without the pattern feature MODE and PATTERN read 0
    cfg_wr(2'd0, 32'd2);
    cfg_rd(2'd0, v); check("nopat_ctrl", v, 32'd0);
    cfg_wr(2'd2, 32'hFF);
    cfg_rd(2'd2, v); check("nopat_pattern", v, 32'd0);
`endif
    cfg_wr(2'd0, 32'd0);
    run(10);

    // disable while a write of 1 is stalled: it completes, then one write of 0
    m_waitrequest = 1;
    cfg_wr(2'd1, 32'd4);
    cfg_wr(2'd0, 32'd1);
    wait_cs("dis_wait", 20);
    check("dis_inflight", m_writedata, 32'd1);
    clr_log();
    cfg_wr(2'd0, 32'd0);
    run(3);
    m_waitrequest = 0;
    run(10);
    check("dis_cnt", iss_cyc.size(), 32'd1);
    if (iss_cyc.size() >= 1) check("dis_data", {31'b0, iss_dat[0]}, 32'd0);
    check("dis_pio", {31'b0, pio_val}, 32'd0);
    cfg_rd(2'd3, v); check("dis_busy", {31'b0, v[1]}, 32'd0);

    // reset during a stalled transfer
    m_waitrequest = 1;
    cfg_wr(2'd0, 32'd1);
    wait_cs("rstw_wait", 20);
    reset = 1;
    @(negedge clk);
    #1;
    check("rstw_cs", {31'b0, m_chipselect}, 32'd0);
    check("rstw_wn", {31'b0, m_write_n}, 32'd1);
    check("rstw_wd", m_writedata, 32'd0);
    reset = 0;
    m_waitrequest = 0;
    cfg_rd(2'd0, v); check("rstw_ctrl", v, 32'd0);
    cfg_rd(2'd1, v); check("rstw_period", v, P_RST);
    cfg_rd(2'd2, v); check("rstw_pattern", v, PAT ? {24'b0, PAT_RST} : 32'd0);
    cfg_rd(2'd3, v); check("rstw_status", v, 32'd0);

    // randomized configuration, reads and wait-states
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      logic [1:0]  a;
      logic [31:0] d;
      m_waitrequest = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 7);
      a = 2'($urandom_range(0, 3));
      if (r == 0) begin
        case (a)
          2'd0:    d = 32'($urandom_range(0, 3)) | ($urandom_range(0, 3) == 0 ? 32'd0 : 32'd1);
          2'd1:    d = 32'($urandom_range(0, 5));
          default: d = $urandom;
        endcase
        cfg_wr(a, d);
      end else if (r == 1) begin
        rd_chk("rand_rd", a);
      end else begin
        run(1);
      end
    end
    m_waitrequest = 0;
    cfg_wr(2'd0, 32'd0);
    run(12);
    check("rand_final_pio", {31'b0, pio_val}, 32'd0);
    rd_chk("rand_final_status", 2'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
